radial_pattern_gen: RTL and testbench
=====================================

// Module: radial_pattern_gen
// PURPOSE
//  Parametrised successor to the fixed 7-ring octagonal VGA pattern generator. Takes
//  hpos/vpos/display_on/hsync/vsync from hvsync_generator. Produces pipelined RGB222
//  plus delay-matched syncs for the uo_out mapping. Adds ring count and width
//  parameters, four frame-latched modes, and a programmable animation speed.
// PARAMETERS
//  H_RES       640  active width; center X = H_RES/2
//  V_RES       480  active height; center Y = V_RES/2
//  NUM_RINGS   7    number of rings drawn (1..15); radius beyond the last ring is black
//  RING_SHIFT  5    ring width = 2**RING_SHIFT pixels
//  FRAME_W     10   frame counter width (>=8)
// PORTS
//  clk          in   1   pixel clock
//  reset        in   1   synchronous, active-high reset
//  hpos         in   10  pixel x from hvsync_generator
//  vpos         in   10  pixel y from hvsync_generator
//  display_on   in   1   active-video flag
//  hsync_in     in   1   hsync from generator
//  vsync_in     in   1   vsync from generator
//  mode         in   2   requested pattern mode (sampled at frame boundary)
//  speed        in   2   animation rate: advance every 2**(3-speed) frames
//  rgb          out  6   {R[1:0],G[1:0],B[1:0]}
//  hsync_out    out  1   hsync_in delayed by LATENCY
//  vsync_out    out  1   vsync_in delayed by LATENCY
//  frame_cnt    out  FRAME_W  animation phase counter
// BEHAVIOUR
//  - Reset: rgb=0, hsync_out=0, vsync_out=0, frame_cnt=0, mode_q=0, speed_q=0,
//    div_cnt=0, all pipe regs 0. Reset mid-frame: outputs are 0 on the next edge.
//  - Frame edge: vsync_in rising edge, detected against a registered copy.
//    * On the edge, latch mode_q<=mode and speed_q<=speed. No mid-frame mode change.
//    * On the edge, div_cnt++. When div_cnt[2:0] reaches 2**(3-speed_q)-1,
//      frame_cnt++ and div_cnt<=0. frame_cnt wraps modulo 2**FRAME_W.
//  - Pipeline, LATENCY=2. The rgb produced at edge N+2 belongs to hpos/vpos at edge N.
//    * S1: dx=|hpos-H_RES/2|, dy=|vpos-V_RES/2| (10b).
//      radius=max+(min>>1), 11b, cannot overflow.
//      Register dx, dy, radius, display_on, hsync_in and vsync_in.
//    * S2: ring=radius>>RING_SHIFT.
//      Pixel is lit iff ring<NUM_RINGS, display_on and the mode bit is set.
//      Otherwise rgb=0. Syncs pass through unmodified.
//  - Mode bits, with ph=frame_cnt[3:0]. ang+ = (dx^dy)+ph; ang- = (dx^dy)-ph, both 8b.
//    * 0 CHECKER: dx[4]^dy[4]^frame_cnt[4]
//    * 1 SPIRAL: odd rings use ang+[4], even rings ang-[4]. Rotation alternates per ring.
//    * 2 SOLID: always 1.
//    * 3 BARS: pixel lit in all rings; colour = hpos[8:6] replicated, ignoring the palette.
//  - Colour: base={frame_cnt[7:6],frame_cnt[5:4],frame_cnt[3:2]}.
//    rgb = base + ring*RING_COLOR_STEP, 6-bit wrap.
//  - Boundary: radius == k*2**RING_SHIFT is the start of ring k.
//    Center pixel (dx=dy=0) is ring 0.
//    hpos = H_RES/2 gives dx=0 (no sign glitch).
// CONFIGURATION
//  GLITTER_EN defined:
//    * Instantiates radial_lfsr16: x^16+x^14+x^13+x^11, seed 16'hACE1 on reset,
//      steps every clk.
//    * In S2, when lfsr[5:0]==0, ring>=NUM_RINGS-2 and display_on, force rgb=6'h3F.
//    * LATENCY is unchanged.
//  GLITTER_EN undefined: no LFSR logic; output is purely deterministic.
// STRUCTURE
//  - Package radial_pattern_pkg:
//    * mode enum {MODE_CHECKER, MODE_SPIRAL, MODE_SOLID, MODE_BARS}
//    * RING_COLOR_STEP=6'b010101
//    * LATENCY=2
//    * LFSR_SEED=16'hACE1
//  - Sub-module radial_lfsr16 (clk, reset, q[15:0]), used only under GLITTER_EN.
//  - Delta, radius and colour maths stay inline.
// TESTING
//  1. Reset: assert reset for 3 clk with video active.
//     -> rgb=0, syncs=0, frame_cnt=0; first valid rgb 2 clk after release.
//  2. Latency/sync: toggle hsync_in at edge N -> hsync_out toggles at edge N+2.
//     vsync_in behaves the same.
//  3. SOLID, frame_cnt=0, NUM_RINGS=7, RING_SHIFT=5:
//     * (320,240) -> rgb=0
//     * (352,240) (radius 32) -> 6'h15
//     * (544,240) (radius 224) -> 0
//  4. Speed: speed=3 -> frame_cnt +1 per vsync; speed=0 -> +1 per 8 vsyncs.
//     8 vsyncs at speed=0 -> frame_cnt=1.
//  5. Mode latch: change mode 0->2 mid-frame -> output stays CHECKER until next vsync rise.
//     From the following line on: SOLID.
//  6. Blanking: display_on=0 at any ring -> rgb=0. With GLITTER_EN, no sparkle in blanking.

Source files
------------

// File: rtl/radial_pattern_pkg.sv
// radial_pattern_pkg
//   Shared definitions for the radial pattern generator: pattern mode
//   encoding, per-ring colour step, pipeline latency and the glitter LFSR seed.
package radial_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_CHECKER = 2'd0,
    MODE_SPIRAL  = 2'd1,
    MODE_SOLID   = 2'd2,
    MODE_BARS    = 2'd3
  } mode_e;

  // Added once per ring index so neighbouring rings get distinct colours.
  localparam logic [5:0]  RING_COLOR_STEP = 6'b010101;

  // Clock edges from hpos/vpos/syncs in to rgb/syncs out.
  localparam int          LATENCY = 2;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/radial_lfsr16.sv
// radial_lfsr16
//   16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11, loaded with
//   LFSR_SEED on reset and stepped on every clock. Drives the glitter sparkle.
// Ports:
//   clk   in   clock
//   reset in   synchronous active-high reset
//   q     out  current LFSR state
module radial_lfsr16
  import radial_pattern_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic        fb;

  // Taps 16,14,13,11 in right-shift form.
  assign fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {fb, lfsr_q[15:1]};
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/radial_pattern_gen.sv
// radial_pattern_gen
//   Draws concentric octagonal rings centred on the active area. Each pixel's
//   octagonal radius selects a ring; the frame-latched mode decides whether the
//   pixel is lit, and the colour rotates with the animation frame counter.
//   Two-stage pipeline; syncs are delayed to match rgb.
// Configuration macro:
//   GLITTER_EN  adds random white sparkles on the outer two rings.
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   hpos, vpos            pixel coordinate (10b)
//   display_on            active-video flag
//   hsync_in, vsync_in    syncs from the timing generator
//   mode                  requested pattern, latched on vsync rising edge
//   speed                 animation rate, frame_cnt advances every 2**(3-speed) frames
//   rgb                   {R[1:0],G[1:0],B[1:0]}
//   hsync_out, vsync_out  syncs delayed by LATENCY
//   frame_cnt             animation phase counter
module radial_pattern_gen
  import radial_pattern_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int NUM_RINGS  = 7,
  parameter int RING_SHIFT = 5,
  parameter int FRAME_W    = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  input  logic               display_on,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [1:0]         mode,
  input  logic [1:0]         speed,
  output logic [5:0]         rgb,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam logic [9:0] CX = 10'(H_RES / 2);
  localparam logic [9:0] CY = 10'(V_RES / 2);

  // ---------------------------------------------------------------- frame
  logic               vsync_prev_q;
  mode_e              mode_q;
  logic [1:0]         speed_q;
  logic [2:0]         div_q;
  logic [FRAME_W-1:0] frame_q;
  logic               frame_edge;
  logic [2:0]         div_limit;

  assign frame_edge = vsync_in & ~vsync_prev_q;
  // 2**(3-speed)-1 : 7, 3, 1, 0
  assign div_limit  = 3'((4'd8 >> speed_q) - 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_prev_q <= 1'b0;
      mode_q       <= MODE_CHECKER;
      speed_q      <= 2'd0;
      div_q        <= 3'd0;
      frame_q      <= '0;
    end else begin
      vsync_prev_q <= vsync_in;
      if (frame_edge) begin
        mode_q  <= mode_e'(mode);
        speed_q <= speed;
        // >= so a speed increase with a large leftover div_q still fires at once
        if (div_q >= div_limit) begin
          frame_q <= frame_q + 1'b1;
          div_q   <= 3'd0;
        end else begin
          div_q   <= div_q + 3'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic [9:0]  dx_d, dy_d, dmax, dmin;
  logic [10:0] radius_d;
  logic [9:0]  dx_q, dy_q;
  logic [10:0] radius_q;
  logic        de_q, hs_q, vs_q;
  logic [2:0]  bar_q;

  always_comb begin
    dx_d     = (hpos >= CX) ? (hpos - CX) : (CX - hpos);
    dy_d     = (vpos >= CY) ? (vpos - CY) : (CY - vpos);
    dmax     = (dx_d >= dy_d) ? dx_d : dy_d;
    dmin     = (dx_d >= dy_d) ? dy_d : dx_d;
    // Octagonal distance approximation: max + min/2.
    radius_d = {1'b0, dmax} + {2'b00, dmin[9:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q     <= '0;
      dy_q     <= '0;
      radius_q <= '0;
      de_q     <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      bar_q    <= '0;
    end else begin
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      radius_q <= radius_d;
      de_q     <= display_on;
      hs_q     <= hsync_in;
      vs_q     <= vsync_in;
      bar_q    <= hpos[8:6];
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [10:0] ring;
  logic        in_rings;
  logic [7:0]  xr, ang_p, ang_m;
  logic        mode_bit;
  logic [5:0]  base, colour, rgb_d;
  logic [5:0]  rgb_q;
  logic        hs_out_q, vs_out_q;

`ifdef GLITTER_EN
  logic [15:0] lfsr;

  radial_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );
`endif

  always_comb begin
    ring     = radius_q >> RING_SHIFT;
    in_rings = (ring < 11'(NUM_RINGS));
    xr       = 8'(dx_q ^ dy_q);
    ang_p    = xr + {4'b0000, frame_q[3:0]};
    ang_m    = xr - {4'b0000, frame_q[3:0]};
    base     = frame_q[7:2];
    colour   = base + 6'(ring[5:0] * RING_COLOR_STEP);

    mode_bit = 1'b0;
    case (mode_q)
      MODE_CHECKER: mode_bit = dx_q[4] ^ dy_q[4] ^ frame_q[4];
      // Odd rings rotate one way, even rings the other.
      MODE_SPIRAL:  mode_bit = |((ring[0] ? ang_p : ang_m) & 8'h10);
      MODE_SOLID:   mode_bit = 1'b1;
      MODE_BARS:    mode_bit = 1'b1;
      default:      mode_bit = 1'b0;
    endcase

    rgb_d = 6'd0;
    if (de_q && in_rings && mode_bit) begin
      rgb_d = (mode_q == MODE_BARS) ? {bar_q, bar_q} : colour;
    end
`ifdef GLITTER_EN
    if (((lfsr & 16'h003F) == 16'd0) && (({1'b0, ring} + 12'd2) >= 12'(NUM_RINGS)) && de_q) begin
      rgb_d = 6'h3F;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q    <= '0;
      hs_out_q <= 1'b0;
      vs_out_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      hs_out_q <= hs_q;
      vs_out_q <= vs_q;
    end
  end

  assign rgb       = rgb_q;
  assign hsync_out = hs_out_q;
  assign vsync_out = vs_out_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_radial_pattern_gen.sv
// tb_radial_pattern_gen
//   Directed bench for radial_pattern_gen with default parameters.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point after the edge at which they are expected.
module tb_radial_pattern_gen;
  import radial_pattern_pkg::*;

  // ---------------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [9:0] hpos, vpos;
  logic       display_on, hsync_in, vsync_in;
  logic [1:0] mode, speed;
  logic [5:0] rgb;
  logic       hsync_out, vsync_out;
  logic [9:0] frame_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  radial_pattern_gen dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .mode       (mode),
    .speed      (speed),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .frame_cnt  (frame_cnt)
  );

  // ---------------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (LATENCY) tick();
  endtask

  task automatic set_pixel(input logic [9:0] x, input logic [9:0] y);
    hpos = x;
    vpos = y;
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset = 1'b1; mode = 2'd0; speed = 2'd0;
    display_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b0;
    set_pixel(10'd368, 10'd240);
    repeat (3) tick();
    n_checks++;
    if (rgb !== 6'h00) $display("FAIL reset_rgb: got %h want 00", rgb); else n_pass++;
    n_checks++;
    if (hsync_out !== 1'b0) $display("FAIL reset_hsync: got %b want 0", hsync_out); else n_pass++;
    n_checks++;
    if (vsync_out !== 1'b0) $display("FAIL reset_vsync: got %b want 0", vsync_out); else n_pass++;
    n_checks++;
    if (frame_cnt !== 10'd0) $display("FAIL reset_frame: got %0d want 0", frame_cnt); else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++;
    if (rgb !== 6'h00) $display("FAIL release_rgb_1clk: got %h want 00", rgb); else n_pass++;
    tick();
    // CHECKER, frame 0, dx=48 -> lit, ring 1
    n_checks++;
    if (rgb !== 6'h15) $display("FAIL release_rgb_2clk: got %h want 15", rgb); else n_pass++;
    n_checks++;
    if (hsync_out !== 1'b1) $display("FAIL release_hsync: got %b want 1", hsync_out); else n_pass++;
  endtask

  task automatic test_latency_sync();
    hsync_in = 1'b0;
    tick();
    n_checks++;
    if (hsync_out !== 1'b1) $display("FAIL hsync_lat1: got %b want 1", hsync_out); else n_pass++;
    tick();
    n_checks++;
    if (hsync_out !== 1'b0) $display("FAIL hsync_lat2: got %b want 0", hsync_out); else n_pass++;
    vsync_in = 1'b1;
    tick();
    n_checks++;
    if (vsync_out !== 1'b0) $display("FAIL vsync_lat1: got %b want 0", vsync_out); else n_pass++;
    tick();
    n_checks++;
    if (vsync_out !== 1'b1) $display("FAIL vsync_lat2: got %b want 1", vsync_out); else n_pass++;
    vsync_in = 1'b0;
    settle();
  endtask

  task automatic test_solid();
    logic [9:0] xs [11] = '{10'd320, 10'd352, 10'd544, 10'd351, 10'd383, 10'd384,
                            10'd543, 10'd320, 10'd288, 10'd352, 10'd320};
    logic [9:0] ys [11] = '{10'd240, 10'd240, 10'd240, 10'd240, 10'd240, 10'd240,
                            10'd240, 10'd272, 10'd240, 10'd272, 10'd208};
    logic [5:0] ex [11] = '{6'h00, 6'h15, 6'h00, 6'h00, 6'h15, 6'h2A,
                            6'h3E, 6'h15, 6'h15, 6'h15, 6'h15};
    mode = 2'd2;
    vsync_pulse();
    for (int i = 0; i < 11; i++) begin
      set_pixel(xs[i], ys[i]);
      settle();
      n_checks++;
      if (rgb !== ex[i])
        $display("FAIL solid(%0d,%0d): got %h want %h", xs[i], ys[i], rgb, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_speed();
    reset = 1'b1; mode = 2'd0; speed = 2'd0;
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (frame_cnt !== 10'd0) $display("FAIL speed_reset: got %0d want 0", frame_cnt); else n_pass++;
    repeat (7) vsync_pulse();
    n_checks++;
    if (frame_cnt !== 10'd0) $display("FAIL speed0_7: got %0d want 0", frame_cnt); else n_pass++;
    vsync_pulse();
    n_checks++;
    if (frame_cnt !== 10'd1) $display("FAIL speed0_8: got %0d want 1", frame_cnt); else n_pass++;
    speed = 2'd3;
    vsync_pulse();
    n_checks++;
    if (frame_cnt !== 10'd1) $display("FAIL speed3_latch: got %0d want 1", frame_cnt); else n_pass++;
    vsync_pulse();
    n_checks++;
    if (frame_cnt !== 10'd2) $display("FAIL speed3_a: got %0d want 2", frame_cnt); else n_pass++;
    vsync_pulse();
    n_checks++;
    if (frame_cnt !== 10'd3) $display("FAIL speed3_b: got %0d want 3", frame_cnt); else n_pass++;
    speed = 2'd1;
    vsync_pulse();
    n_checks++;
    if (frame_cnt !== 10'd4) $display("FAIL speed1_latch: got %0d want 4", frame_cnt); else n_pass++;
    repeat (3) vsync_pulse();
    n_checks++;
    if (frame_cnt !== 10'd4) $display("FAIL speed1_3: got %0d want 4", frame_cnt); else n_pass++;
    vsync_pulse();
    n_checks++;
    if (frame_cnt !== 10'd5) $display("FAIL speed1_4: got %0d want 5", frame_cnt); else n_pass++;
  endtask

  // frame_cnt is 5 from here on: base colour 1, ph 5, frame_cnt[4]=0
  task automatic test_mode_latch();
    set_pixel(10'd368, 10'd240);
    settle();
    n_checks++;
    if (rgb !== 6'h16) $display("FAIL checker_lit: got %h want 16", rgb); else n_pass++;
    set_pixel(10'd352, 10'd240);
    settle();
    n_checks++;
    if (rgb !== 6'h00) $display("FAIL checker_dark: got %h want 00", rgb); else n_pass++;
    mode = 2'd2;
    repeat (3) tick();
    n_checks++;
    if (rgb !== 6'h00) $display("FAIL mode_midframe: got %h want 00", rgb); else n_pass++;
    vsync_pulse();
    settle();
    n_checks++;
    if (rgb !== 6'h16) $display("FAIL mode_after_vsync: got %h want 16", rgb); else n_pass++;
  endtask

  task automatic test_modes();
    mode = 2'd3;
    vsync_pulse();
    set_pixel(10'd352, 10'd240);
    settle();
    n_checks++;
    if (rgb !== 6'h2D) $display("FAIL bars_in: got %h want 2d", rgb); else n_pass++;
    set_pixel(10'd544, 10'd240);
    settle();
    n_checks++;
    if (rgb !== 6'h00) $display("FAIL bars_out: got %h want 00", rgb); else n_pass++;
    mode = 2'd1;
    vsync_pulse();
    set_pixel(10'd368, 10'd240);
    settle();
    n_checks++;
    if (rgb !== 6'h16) $display("FAIL spiral_odd_lit: got %h want 16", rgb); else n_pass++;
    set_pixel(10'd352, 10'd240);
    settle();
    n_checks++;
    if (rgb !== 6'h00) $display("FAIL spiral_odd_dark: got %h want 00", rgb); else n_pass++;
    set_pixel(10'd384, 10'd240);
    settle();
    n_checks++;
    if (rgb !== 6'h2B) $display("FAIL spiral_even_lit: got %h want 2b", rgb); else n_pass++;
    set_pixel(10'd336, 10'd240);
    settle();
    n_checks++;
    if (rgb !== 6'h00) $display("FAIL spiral_even_dark: got %h want 00", rgb); else n_pass++;
  endtask

  task automatic test_blanking();
    display_on = 1'b0;
    set_pixel(10'd368, 10'd240);
    settle();
    n_checks++;
    if (rgb !== 6'h00) $display("FAIL blank_ring1: got %h want 00", rgb); else n_pass++;
    set_pixel(10'd384, 10'd240);
    settle();
    n_checks++;
    if (rgb !== 6'h00) $display("FAIL blank_ring2: got %h want 00", rgb); else n_pass++;
    display_on = 1'b1;
    settle();
    n_checks++;
    if (rgb !== 6'h2B) $display("FAIL unblank: got %h want 2b", rgb); else n_pass++;
  endtask

  // ---------------------------------------------------------------- sequence / report
  initial begin
    test_reset();
    test_latency_sync();
    test_solid();
    test_speed();
    test_mode_latch();
    test_modes();
    test_blanking();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
